uart_tx_feeder: RTL and testbench

- Byte buffer and launch sequencer directly upstream of the UART transmitter FSM.
- Accepts bytes from host logic through a valid/ready write port and queues them in a small synchronous FIFO.
- Drives the transmitter's tx_data/tx_start one byte at a time, using its tx_busy/tx_done handshake so back-to-back bytes go out without host pacing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_feeder_if.sv | 26 ++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_feeder.sv | 133 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and the feeder FSM state encoding for the UART TX feeder.
`timescale 1ns/1ps

package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port and transmitter launch handshake bundled together.
// master: host + transmitter side; slave: the feeder.
`timescale 1ns/1ps

interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   tx_done;

  modport master (
    output wr_data, wr_valid, tx_busy, tx_done,
    input  wr_ready, tx_data, tx_start
  );

  modport slave (
    input  wr_data, wr_valid, tx_busy, tx_done,
    output wr_ready, tx_data, tx_start
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers, occupancy count and
// full/empty flags derived from the registered count.
`timescale 1ns/1ps

module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [UART_DATA_W-1:0] din_i,
  input  logic                   pop_i,
  output logic [UART_DATA_W-1:0] dout_o,
  output logic [AW:0]            count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW:0]            count_q;
  logic [AW:0]            count_d;

  // Storage is not reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer advance, wrapping naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer in front of the UART transmitter.
// Optional watchdog on the wait states: define UART_TX_FEEDER_WDOG_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter
// WAIT_BUSY | byte launched, waiting for transmitter to report busy
// WAIT_DONE | transmitter busy, waiting for its completion pulse
`timescale 1ns/1ps

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
`ifdef UART_TX_FEEDER_WDOG_EN
  , parameter int WDOG_CYCLES = 1023
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_tx_feeder_if.slave bus,
  output logic [AW:0] fifo_count,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow
`ifdef UART_TX_FEEDER_WDOG_EN
  , output logic      wdog_trip
`endif
);

  feeder_state_e          state_q;
  feeder_state_e          state_d;
  logic [UART_DATA_W-1:0] tx_data_q;
  logic [UART_DATA_W-1:0] tx_data_d;
  logic                   tx_start_q;
  logic                   overflow_q;
  logic                   launch;
  logic                   push;
  logic [UART_DATA_W-1:0] fifo_head;

  // Ready is taken from the registered count, so a same-cycle pop never
  // opens a slot for a write.
  assign push         = bus.wr_valid && !fifo_full;
  assign bus.wr_ready = !fifo_full;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (bus.wr_data),
    .pop_i   (launch),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

`ifdef UART_TX_FEEDER_WDOG_EN
  localparam logic [9:0] WDOG_LAST = 10'(WDOG_CYCLES - 1);

  logic [9:0] wdog_cnt_q;
  logic       wdog_trip_q;
  logic       wdog_hit;

  assign wdog_hit = (state_q != IDLE) && (wdog_cnt_q == WDOG_LAST);

  // Cycle counter for time spent waiting on the transmitter.
  always_ff @(posedge clk) begin
    if (!rst_n)                wdog_cnt_q <= '0;
    else if (launch)           wdog_cnt_q <= '0;
    else if (state_q != IDLE)  wdog_cnt_q <= wdog_cnt_q + 10'd1;
  end

  // Sticky trip flag.
  always_ff @(posedge clk) begin
    if (!rst_n) wdog_trip_q <= 1'b0;
    else        wdog_trip_q <= wdog_trip_q | wdog_hit;
  end

  assign wdog_trip = wdog_trip_q;
`endif

  // Next-state and launch decode.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          launch  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_done)      state_d = IDLE;
        else if (bus.tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_FEEDER_WDOG_EN
    if (wdog_hit) state_d = IDLE;
`endif
  end

  assign tx_data_d = launch ? fifo_head : tx_data_q;

  // State, launch outputs and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= launch;
      overflow_q <= overflow_q | (bus.wr_valid && fifo_full);
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter model.
`timescale 1ns/1ps

module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
`ifdef UART_TX_FEEDER_WDOG_EN
  logic          wdog_trip;
`endif

  uart_tx_feeder_if bus();

  logic model_en   = 1'b0;
  logic model_busy = 1'b0;
  logic model_done = 1'b0;
  logic hold_busy  = 1'b0;
  int   busy_len   = 5;

  assign bus.tx_busy = model_busy | hold_busy;
  assign bus.tx_done = model_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] starts[$];
  int   busy_viol = 0;
  int   gap_viol = 0;
  int   last_done_cyc = -1000;
  logic prev_busy = 1'b0;

`ifdef UART_TX_FEEDER_WDOG_EN
  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .WDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .wdog_trip(wdog_trip)
  );
`else
  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: records launched bytes, launches decided while busy,
  // and launches closer than one idle cycle after a completion pulse.
  always @(negedge clk) begin
    if (bus.tx_start) begin
      starts.push_back(bus.tx_data);
      if (prev_busy) busy_viol++;
      if (cyc - last_done_cyc < 2) gap_viol++;
    end
    if (bus.tx_done) last_done_cyc = cyc;
    prev_busy = bus.tx_busy;
  end

  // Transmitter model: busy for busy_len cycles after a launch, then a
  // one-cycle done pulse as busy falls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (model_en && bus.tx_start) begin
        model_busy = 1'b1;
        repeat (busy_len - 1) begin @(posedge clk); #1; end
        model_busy = 1'b0;
        model_done = 1'b1;
        @(posedge clk); #1;
        model_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
    tick(); tick();
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef UART_TX_FEEDER_WDOG_EN
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_wdog_trip: got %b expected 0", wdog_trip); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    model_en = 1'b1; busy_len = 5; base = starts.size();
    bus.wr_data = 8'hA5; bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count_after_write: got %0d expected 1", fifo_count); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b expected 0", bus.tx_start); end
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", bus.tx_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", fifo_count); end
    tick();
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", bus.tx_start); end
    repeat (10) tick();
    checks++; if (starts.size() !== base + 1) begin errors++; $display("FAIL single_launch_count: got %0d expected %0d", starts.size() - base, 1); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h expected a5", bus.tx_data); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_burst();
    int base, bv, gv;
    busy_len = 20; base = starts.size(); bv = busy_viol; gv = gap_viol;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'(i + 1); bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 400 && starts.size() < base + 4; i++) tick();
    repeat (30) tick();
    checks++; if (starts.size() !== base + 4) begin errors++; $display("FAIL burst_launch_count: got %0d expected 4", starts.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < starts.size()) begin
        checks++;
        if (starts[base + i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_order[%0d]: got %h expected %h", i, starts[base + i], 8'(i + 1)); end
      end
    end
    checks++; if (busy_viol !== bv) begin errors++; $display("FAIL burst_launch_while_busy: got %0d expected %0d", busy_viol, bv); end
    checks++; if (gap_viol !== gv) begin errors++; $display("FAIL burst_gap_after_done: got %0d expected %0d", gap_viol, gv); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL burst_count_end: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_full_overflow();
    int base;
    model_en = 1'b0; hold_busy = 1'b1; base = starts.size();
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = 8'h10 + 8'(i); bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_data = 8'h18;
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", bus.wr_ready); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", fifo_full); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_early: got %b expected 0", overflow); end
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_set: got %b expected 1", overflow); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count_after_drop: got %0d expected 8", fifo_count); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_sticky: got %b expected 1", overflow); end
    hold_busy = 1'b0; busy_len = 3; model_en = 1'b1;
    for (int i = 0; i < 300 && starts.size() < base + 8; i++) tick();
    repeat (20) tick();
    checks++; if (starts.size() !== base + 8) begin errors++; $display("FAIL full_launch_count: got %0d expected 8", starts.size() - base); end
    for (int i = 0; i < 8; i++) begin
      if (base + i < starts.size()) begin
        checks++;
        if (starts[base + i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h expected %h", i, starts[base + i], 8'h10 + 8'(i)); end
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b expected 1", fifo_empty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow_kept: got %b expected 1", overflow); end
  endtask

  task automatic test_push_pop();
    int base, gv;
    model_en = 1'b0; hold_busy = 1'b1; base = starts.size(); gv = gap_viol;
    bus.wr_data = 8'h31; bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pp_count_setup: got %0d expected 1", fifo_count); end
    hold_busy = 1'b0; model_en = 1'b1; busy_len = 4;
    bus.wr_data = 8'h32; bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pp_count_push_pop: got %0d expected 1", fifo_count); end
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL pp_start: got %b expected 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h31) begin errors++; $display("FAIL pp_data_first: got %h expected 31", bus.tx_data); end
    for (int i = 0; i < 100 && starts.size() < base + 2; i++) tick();
    repeat (10) tick();
    checks++; if (starts.size() !== base + 2) begin errors++; $display("FAIL pp_launch_count: got %0d expected 2", starts.size() - base); end
    if (starts.size() >= base + 2) begin
      checks++; if (starts[base + 1] !== 8'h32) begin errors++; $display("FAIL pp_data_second: got %h expected 32", starts[base + 1]); end
    end
    checks++; if (gap_viol !== gv) begin errors++; $display("FAIL pp_gap_after_done: got %0d expected %0d", gap_viol, gv); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL pp_count_end: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    int base;
    model_en = 1'b0; hold_busy = 1'b0; base = starts.size();
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'h40 + 8'(i); bus.wr_valid = 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
    hold_busy = 1'b1;
    tick(); tick();
    checks++; if (fifo_count !== 4'd5) begin errors++; $display("FAIL rm_count_queued: got %0d expected 5", fifo_count); end
    checks++; if (starts.size() !== base + 1) begin errors++; $display("FAIL rm_one_launched: got %0d expected 1", starts.size() - base); end
    rst_n = 1'b0;
    tick();
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", fifo_count); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rm_empty: got %b expected 1", fifo_empty); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rm_tx_start: got %b expected 0", bus.tx_start); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rm_overflow: got %b expected 0", overflow); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rm_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rm_wr_ready: got %b expected 1", bus.wr_ready); end
    rst_n = 1'b1; hold_busy = 1'b0; model_en = 1'b1; busy_len = 3;
    repeat (20) tick();
    checks++; if (starts.size() !== base + 1) begin errors++; $display("FAIL rm_no_relaunch: got %0d expected 1", starts.size() - base); end
    bus.wr_data = 8'h77; bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("FAIL rm_idle_launch: got %b expected 1", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h77) begin errors++; $display("FAIL rm_idle_data: got %h expected 77", bus.tx_data); end
    repeat (10) tick();
    model_en = 1'b0;
  endtask

`ifdef UART_TX_FEEDER_WDOG_EN
  task automatic test_wdog();
    int t;
    model_en = 1'b0; hold_busy = 1'b0;
    bus.wr_data = 8'h50; bus.wr_valid = 1'b1;
    tick();
    bus.wr_data = 8'h51;
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h50) begin errors++; $display("FAIL wdog_first_launch: got start=%b data=%h expected 1/50", bus.tx_start, bus.tx_data); end
    t = 0;
    while (wdog_trip !== 1'b1 && t < 60) begin tick(); t++; end
    checks++; if (t !== 16) begin errors++; $display("FAIL wdog_latency: got %0d cycles expected 16", t); end
    checks++; if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_trip: got %b expected 1", wdog_trip); end
    tick();
    checks++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h51) begin errors++; $display("FAIL wdog_next_launch: got start=%b data=%h expected 1/51", bus.tx_start, bus.tx_data); end
    repeat (20) tick();
    checks++; if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", wdog_trip); end
  endtask
`endif

  initial begin
    bus.wr_data = 8'h00;
    bus.wr_valid = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_push_pop();
    test_reset_mid();
`ifdef UART_TX_FEEDER_WDOG_EN
    test_wdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
